muldiv_seq: RTL and testbench

- Parametrised, multicycle integer multiply/divide unit for the multicycle CPU datapath; successor to the fixed 32-bit mult/div block.
- Generalised to WIDTH bits, with four explicit modes (signed/unsigned × mult/div) and a start/busy/done handshake.
- Results go to the HI/LO architectural registers under control-unit write enables; the divide-by-zero flag feeds the exception path.

---
 rtl/muldiv_seq.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq -- multicycle integer multiply/divide unit.
//
// Performs one radix-2 step per clock:
//   - multiply: shift-add on a 2*WIDTH accumulator
//   - divide:   restoring shift-subtract
// Operands are reduced to magnitudes on acceptance. The sign is applied in a
// single FIX cycle before hi/lo are loaded.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   start        request, sampled only while idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend, multiplier/divisor
//   hi, lo       product upper/lower half, or remainder/quotient
//   busy         high while an operation is computing or being finalised
//   done         one-cycle completion pulse
//   div_by_zero  sticky flag; set by a divide with b=0, cleared on the next
//                accepted start
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DZ   = 2'd3
  } state_t;

  // Magnitude of an operand. The most-negative value maps onto itself, which
  // is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x,
                                               input logic             is_signed);
    logic signed [WIDTH-1:0] xs;
    xs = $signed(x);
    if (is_signed && xs[WIDTH-1]) abs_mag = $unsigned(-xs);
    else                          abs_mag = x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    cond_neg = neg ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                   input logic               neg);
    cond_neg2 = neg ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;      // dividend sign: remainder sign
  logic               neg_res_q, neg_res_d;  // operand signs differ
  logic [2*WIDTH-1:0] acc_q, acc_d;          // product, or quotient in low half
  logic [WIDTH-1:0]   rem_q, rem_d;          // partial remainder (always < divisor)
  logic [WIDTH-1:0]   m_q, m_d;              // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               signed_op;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fix;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  // Working registers carry no reset: they are always reloaded on acceptance.
  always_ff @(posedge clock) begin
    is_div_q  <= is_div_d;
    neg_a_q   <= neg_a_d;
    neg_res_q <= neg_res_d;
    acc_q     <= acc_d;
    rem_q     <= rem_d;
    m_q       <= m_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_a_d   = neg_a_q;
    neg_res_d = neg_res_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    signed_op = ~op[0];
    sgn_a     = signed_op & a[WIDTH-1];
    sgn_b     = signed_op & b[WIDTH-1];
    mag_a     = abs_mag(a, signed_op);
    mag_b     = abs_mag(b, signed_op);
    shifted   = {rem_q, acc_q[WIDTH-1]};
    diff      = {1'b0, shifted} - {2'b00, m_q};
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    prod_fix  = cond_neg2(acc_q, neg_res_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            dz_d    = 1'b1;
            state_d = S_DZ;
          end else begin
            dz_d      = 1'b0;
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = op[1];
            neg_a_d   = sgn_a;
            neg_res_d = sgn_a ^ sgn_b;
            rem_d     = '0;
            // Low half of acc shifts out the multiplier (mult) or the
            // dividend while shifting in quotient bits (div).
            if (op[1]) begin
              acc_d = {{WIDTH{1'b0}}, mag_a};
              m_d   = mag_b;
            end else begin
              acc_d = {{WIDTH{1'b0}}, mag_b};
              m_d   = mag_a;
            end
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          // diff[WIDTH+1] is the borrow: set means the trial subtract failed.
          if (!diff[WIDTH+1]) begin
            rem_d              = WIDTH'(diff);
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d              = WIDTH'(shifted);
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = cond_neg(rem_q, neg_a_q);
          lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_DZ: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: a 32-bit instance for the arithmetic and
// handshake, an 8-bit instance for mid-operation start/reset behaviour.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32_n, start32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        rst8_n, start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst32_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dz32)
  );

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst8_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  // Reference: returns {dz, hi, lo}; on divide by zero hi/lo keep phi/plo.
  function automatic logic [64:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] phi, input logic [31:0] plo);
    longint unsigned mask, ua, ub, p, rh, rl;
    longint sa, sb, q, r;
    logic dz;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = (ua >= (64'd1 << (w - 1))) ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb = (ub >= (64'd1 << (w - 1))) ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    dz = 1'b0;
    rh = {32'd0, phi};
    rl = {32'd0, plo};
    case (op)
      2'b00: begin p = $unsigned(sa * sb); rh = (p >> w) & mask; rl = p & mask; end
      2'b01: begin p = ua * ub;            rh = (p >> w) & mask; rl = p & mask; end
      2'b10: begin
        if (ub == 0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; rl = $unsigned(q) & mask; rh = $unsigned(r) & mask; end
      end
      default: begin
        if (ub == 0) dz = 1'b1;
        else begin rl = ua / ub; rh = ua % ub; end
      end
    endcase
    model = {dz, rh[31:0], rl[31:0]};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: pick32 = 32'h0000_0000;
      1: pick32 = 32'h0000_0001;
      2: pick32 = 32'hFFFF_FFFF;
      3: pick32 = 32'h8000_0000;
      4: pick32 = 32'h7FFF_FFFF;
      5: pick32 = 32'($urandom_range(0, 255));
      default: pick32 = $urandom;
    endcase
  endfunction

  // Issue one op on the 32-bit instance and follow it to done (bounded).
  // lat = edge count after the accepting edge at which done was seen.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz_acc, output logic dz_end,
                       output int lat, output int busy_n);
    @(negedge clk);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    dz_acc = dz32;
    busy_n = busy32 ? 1 : 0;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy32) busy_n++;
    end
    hi = hi32; lo = lo32; dz_end = dz32;
  endtask

  task automatic test_reset();
    rst32_n = 1'b0; rst8_n = 1'b0;
    start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hi32, lo32} !== 64'd0) begin errors++; $display("FAIL reset_hilo32 got %h want 0", {hi32, lo32}); end
    checks++;
    if ({busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL reset_ctrl32 got %b want 000", {busy32, done32, dz32}); end
    checks++;
    if ({hi8, lo8, busy8, done8, dz8} !== 19'd0) begin errors++; $display("FAIL reset_w8 got %h want 0", {hi8, lo8, busy8, done8, dz8}); end
    @(negedge clk);
    rst32_n = 1'b1; rst8_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] hi, lo;
    logic dza, dze;
    int lat, bn;
    // MULTU max*max
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dza, dze, lat, bn);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++;
    if (bn !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bn); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got %h want fffffffe00000001", {hi, lo}); end
    // MULT -3*7
    run32(2'b00, 32'hFFFF_FFFD, 32'd7, hi, lo, dza, dze, lat, bn);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg got %h want ffffffffffffffeb", {hi, lo}); end
    // DIV -7/2
    run32(2'b10, 32'hFFFF_FFF9, 32'd2, hi, lo, dza, dze, lat, bn);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffffffffffd", {hi, lo}); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    // DIVU 59/6 leaves hi=5 lo=9, then divide by zero must keep them
    run32(2'b11, 32'd59, 32'd6, hi, lo, dza, dze, lat, bn);
    checks++;
    if ({hi, lo} !== {32'd5, 32'd9}) begin errors++; $display("FAIL divu_59_6 got %h want 0000000500000009", {hi, lo}); end
    run32(2'b11, 32'd100, 32'd0, hi, lo, dza, dze, lat, bn);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++;
    if ({dza, dze} !== 2'b11) begin errors++; $display("FAIL dz_flag got %b want 11", {dza, dze}); end
    checks++;
    if ({hi, lo} !== {32'd5, 32'd9}) begin errors++; $display("FAIL dz_hold got %h want 0000000500000009", {hi, lo}); end
    checks++;
    if (bn !== 0) begin errors++; $display("FAIL dz_busy got %0d want 0", bn); end
    // MULTU 2*3 clears the flag on acceptance
    run32(2'b01, 32'd2, 32'd3, hi, lo, dza, dze, lat, bn);
    checks++;
    if ({dza, dze} !== 2'b00) begin errors++; $display("FAIL dz_clear got %b want 00", {dza, dze}); end
    checks++;
    if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL multu_2_3 got %h want 6", {hi, lo}); end
    // DIV most-negative / -1
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dza, dze, lat, bn);
    checks++;
    if ({dze, hi, lo} !== {1'b0, 32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_ovf got %h want 0_00000000_80000000", {dze, hi, lo}); end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, ra, rb, m_hi, m_lo;
    logic [1:0] rop;
    logic [64:0] exp;
    logic dza, dze;
    int lat, bn;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pick32();
      rb = pick32();
      if (i == 0 && rb == 32'd0) rb = 32'd3;
      else if ($urandom_range(0, 7) == 0) rb = 32'd0;
      exp = model(32, rop, ra, rb, m_hi, m_lo);
      run32(rop, ra, rb, hi, lo, dza, dze, lat, bn);
      checks++;
      if ({hi, lo} !== exp[63:0]) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", rop, ra, rb, {hi, lo}, exp[63:0]); end
      checks++;
      if (dze !== exp[64]) begin errors++; $display("FAIL rand_dz op=%0d b=%h got %b want %b", rop, rb, dze, exp[64]); end
      checks++;
      if (lat !== (exp[64] ? 1 : 33)) begin errors++; $display("FAIL rand_latency op=%0d got %0d want %0d", rop, lat, exp[64] ? 1 : 33); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      @(posedge clk); #1;
      checks++;
      if (done32 !== 1'b0) begin errors++; $display("FAIL rand_done_pulse got %b want 0", done32); end
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] e1, e2;
    int lat;
    e1 = model(32, 2'b01, 32'd1234, 32'd5678, 32'd0, 32'd0);
    e2 = model(32, 2'b10, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b01; a32 = 32'd1234; b32 = 32'd5678;
    @(posedge clk); #1;
    op32 = 2'b10; a32 = 32'hFFFF_FF9C; b32 = 32'd7;   // start stays high
    lat = 0;
    while (!done32 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({lat, hi32, lo32} !== {32'd33, e1[63:0]}) begin errors++; $display("FAIL b2b_first got lat=%0d %h want lat=33 %h", lat, {hi32, lo32}, e1[63:0]); end
    @(posedge clk); #1;
    checks++;
    if ({busy32, done32} !== 2'b10) begin errors++; $display("FAIL b2b_accept got busy,done=%b want 10", {busy32, done32}); end
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({lat, hi32, lo32} !== {32'd33, e2[63:0]}) begin errors++; $display("FAIL b2b_second got lat=%0d %h want lat=33 %h", lat, {hi32, lo32}, e2[63:0]); end
  endtask

  task automatic test_w8_ignore();
    int done_edge;
    done_edge = -1;
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b11; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk); #1;   // edge 0
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e == 3 || e == 5) begin start8 = 1'b1; op8 = 2'b00; a8 = 8'd13; b8 = 8'd11; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      if (done8 && done_edge < 0) done_edge = e;
    end
    start8 = 1'b0;
    checks++;
    if (done_edge !== 9) begin errors++; $display("FAIL w8_done_edge got %0d want 9", done_edge); end
    checks++;
    if ({hi8, lo8} !== {8'd4, 8'd28}) begin errors++; $display("FAIL w8_divu got hi=%0d lo=%0d want hi=4 lo=28", hi8, lo8); end
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, hi8, lo8} !== {2'b00, 8'd4, 8'd28}) begin errors++; $display("FAIL w8_after got %h want 00_041c", {busy8, done8, hi8, lo8}); end
  endtask

  task automatic test_w8_reset();
    int pulses;
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b11; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk); #1;   // edge 0
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8_n = 1'b0;
    @(posedge clk); #1;   // edge 4
    checks++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin errors++; $display("FAIL w8_reset got busy=%b done=%b hi=%0d lo=%0d want all 0", busy8, done8, hi8, lo8); end
    @(negedge clk);
    rst8_n = 1'b1;
    pulses = 0;
    repeat (20) begin @(posedge clk); #1; if (done8) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL w8_no_done got %0d pulses want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_w8_ignore();
    test_w8_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
